// File: rtl/spi_voice_cmd_decoder.sv
// spi_voice_cmd_decoder: decodes NOTEON/NOTEOFF/PITCHBEND byte messages into a command FIFO.
// Latency: command visible on o_cmd_valid one cycle after the final byte strobe (FIFO empty).
// Backpressure: show-ahead FIFO with valid/ready; a commit into a full FIFO with no pop is dropped and counted.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_rx_byte, i_rx_valid   received byte and its one-cycle strobe
//   o_cmd_valid/i_cmd_ready output handshake; head popped on valid & ready
//   o_cmd_type              0=NOTEOFF 1=NOTEON 2=PITCHBEND
//   o_cmd_voice/note/velocity/bend  head payload (all zero while the FIFO is empty)
//   o_err_count             saturating count of framing, timeout and overflow errors
// Build option: define NOTEON_VEL0_AS_OFF_EN to commit NOTEON with velocity 0 as NOTEOFF.

// spi_voice_cmd_fifo: generic show-ahead FIFO, pointers carry a wrap bit.
// Latency: a write is readable on rd_dat_o the cycle after it is accepted.
// Backpressure: write accepted when not full or when a pop happens in the same cycle.
module spi_voice_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         wr_vld_i,
    input  logic [W-1:0] wr_dat_i,
    output logic         full_o,
    output logic         rd_vld_o,
    input  logic         rd_rdy_i,
    output logic [W-1:0] rd_dat_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         empty;
    logic         rd_en;
    logic         wr_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_vld_o = !empty;
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot the write needs.
    assign rd_en = rd_rdy_i && !empty;
    assign wr_en = wr_vld_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
endmodule

module spi_voice_cmd_decoder #(
    parameter int NUM_VOICES     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int VOICE_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_byte,
    input  logic               i_rx_valid,
    output logic               o_cmd_valid,
    input  logic               i_cmd_ready,
    output logic [1:0]         o_cmd_type,
    output logic [VOICE_W-1:0] o_cmd_voice,
    output logic [6:0]         o_cmd_note,
    output logic [6:0]         o_cmd_velocity,
    output logic [13:0]        o_cmd_bend,
    output logic [7:0]         o_err_count
);
    localparam int          TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          CMD_W       = 2 + VOICE_W + 7 + 7 + 14;
    localparam logic [13:0] BEND_CENTRE = 14'h2000;
    localparam logic [1:0]  TYPE_OFF    = 2'd0;
    localparam logic [1:0]  TYPE_ON     = 2'd1;
    localparam logic [1:0]  TYPE_BEND   = 2'd2;

`ifdef NOTEON_VEL0_AS_OFF_EN
    localparam bit VEL0_AS_OFF = 1'b1;
`else
    localparam bit VEL0_AS_OFF = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_VOICE, S_DATA1, S_DATA2} state_e;

    state_e             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [VOICE_W-1:0] voice_q, voice_d;
    logic [6:0]         d1_q, d1_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic               hdr_vld;
    logic [1:0]         hdr_type;
    logic               voice_ok;
    logic               parse_err;
    logic               commit;
    logic [1:0]         c_type;
    logic [VOICE_W-1:0] c_voice;
    logic [6:0]         c_note;
    logic [6:0]         c_vel;
    logic [13:0]        c_bend;

    logic               fifo_full;
    logic               fifo_vld;
    logic [CMD_W-1:0]   head_dat;
    logic [1:0]         h_type;
    logic [VOICE_W-1:0] h_voice;
    logic [6:0]         h_note;
    logic [6:0]         h_vel;
    logic [13:0]        h_bend;
    logic               pop;
    logic               overflow;

    // Header byte classification; also used to restart on an unexpected header.
    always_comb begin
        hdr_vld  = 1'b1;
        hdr_type = TYPE_OFF;
        case (i_rx_byte)
            8'h90:   hdr_type = TYPE_ON;
            8'h80:   hdr_type = TYPE_OFF;
            8'hE0:   hdr_type = TYPE_BEND;
            default: hdr_vld  = 1'b0;
        endcase
    end

    assign voice_ok = !i_rx_byte[7] && ({1'b0, i_rx_byte} < 9'(NUM_VOICES));

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        voice_d   = voice_q;
        d1_d      = d1_q;
        tmo_cnt_d = tmo_cnt_q;
        parse_err = 1'b0;
        commit    = 1'b0;
        c_type    = type_q;
        c_voice   = voice_q;
        c_note    = 7'd0;
        c_vel     = 7'd0;
        c_bend    = BEND_CENTRE;

        if (i_rx_valid) begin
            tmo_cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (hdr_vld) begin
                        type_d  = hdr_type;
                        state_d = S_VOICE;
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                S_VOICE: begin
                    if (voice_ok) begin
                        voice_d = i_rx_byte[VOICE_W-1:0];
                        if (type_q == TYPE_OFF) begin
                            commit  = 1'b1;
                            c_type  = TYPE_OFF;
                            c_voice = i_rx_byte[VOICE_W-1:0];
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA1;
                        end
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                S_DATA1: begin
                    if (!i_rx_byte[7]) begin
                        d1_d    = i_rx_byte[6:0];
                        state_d = S_DATA2;
                    end else begin
                        parse_err = 1'b1;
                    end
                end
                default: begin
                    if (!i_rx_byte[7]) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                        if (type_q == TYPE_BEND) begin
                            c_bend = {i_rx_byte[6:0], d1_q};
                        end else if (VEL0_AS_OFF && (i_rx_byte[6:0] == 7'd0)) begin
                            c_type = TYPE_OFF;
                        end else begin
                            c_note = d1_q;
                            c_vel  = i_rx_byte[6:0];
                        end
                    end else begin
                        parse_err = 1'b1;
                    end
                end
            endcase
            // A broken message that ends on a valid header starts the next message.
            if (parse_err && (state_q != S_IDLE)) begin
                if (hdr_vld) begin
                    type_d  = hdr_type;
                    state_d = S_VOICE;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
                parse_err = 1'b1;
                state_d   = S_IDLE;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    assign pop      = fifo_vld && i_cmd_ready;
    assign overflow = commit && fifo_full && !pop;

    // Parse/timeout errors and overflow never coincide, but OR keeps it one count per cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((parse_err || overflow) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            type_q    <= TYPE_OFF;
            voice_q   <= '0;
            d1_q      <= '0;
            tmo_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            voice_q   <= voice_d;
            d1_q      <= d1_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    spi_voice_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (i_clk),
        .reset_i  (i_reset),
        .wr_vld_i (commit),
        .wr_dat_i ({c_type, c_voice, c_note, c_vel, c_bend}),
        .full_o   (fifo_full),
        .rd_vld_o (fifo_vld),
        .rd_rdy_i (i_cmd_ready),
        .rd_dat_o (head_dat)
    );

    assign {h_type, h_voice, h_note, h_vel, h_bend} = head_dat;

    // Payload reads as zero while empty so stale FIFO contents never leak out.
    assign o_cmd_valid    = fifo_vld;
    assign o_cmd_type     = fifo_vld ? h_type  : '0;
    assign o_cmd_voice    = fifo_vld ? h_voice : '0;
    assign o_cmd_note     = fifo_vld ? h_note  : '0;
    assign o_cmd_velocity = fifo_vld ? h_vel   : '0;
    assign o_cmd_bend     = fifo_vld ? h_bend  : '0;
    assign o_err_count    = err_cnt_q;
endmodule

// File: tb/tb_spi_voice_cmd_decoder.sv
// Bench for spi_voice_cmd_decoder: message-level reference model plus directed literal checks.
module tb_spi_voice_cmd_decoder;
    localparam int NV   = 16;
    localparam int FD   = 4;
    localparam int TMO  = 20;
    localparam int VW   = (NV > 1) ? $clog2(NV) : 1;

    typedef struct packed {
        logic [1:0]    typ;
        logic [VW-1:0] voice;
        logic [6:0]    note;
        logic [6:0]    vel;
        logic [13:0]   bend;
    } cmd_t;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [7:0]    i_rx_byte = 8'h00;
    logic          i_rx_valid = 1'b0;
    logic          o_cmd_valid;
    logic          i_cmd_ready = 1'b0;
    logic [1:0]    o_cmd_type;
    logic [VW-1:0] o_cmd_voice;
    logic [6:0]    o_cmd_note;
    logic [6:0]    o_cmd_velocity;
    logic [13:0]   o_cmd_bend;
    logic [7:0]    o_err_count;

    spi_voice_cmd_decoder #(
        .NUM_VOICES     (NV),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx_byte      (i_rx_byte),
        .i_rx_valid     (i_rx_valid),
        .o_cmd_valid    (o_cmd_valid),
        .i_cmd_ready    (i_cmd_ready),
        .o_cmd_type     (o_cmd_type),
        .o_cmd_voice    (o_cmd_voice),
        .o_cmd_note     (o_cmd_note),
        .o_cmd_velocity (o_cmd_velocity),
        .o_cmd_bend     (o_cmd_bend),
        .o_err_count    (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (message buffer + command queue) ----------------
    cmd_t       mq[$];
    logic [7:0] cur[$];
    int         idle_cnt = 0;
    int         merr = 0;

    function automatic bit is_hdr(input logic [7:0] b);
        return (b == 8'h90) || (b == 8'h80) || (b == 8'hE0);
    endfunction

    function automatic cmd_t build(input logic [7:0] h, input logic [7:0] v,
                                   input logic [7:0] d1, input logic [7:0] d2);
        cmd_t c;
        c = '0;
        c.voice = v[VW-1:0];
        c.bend  = 14'h2000;
        if (h == 8'h80) begin
            c.typ = 2'd0;
        end else if (h == 8'hE0) begin
            c.typ  = 2'd2;
            c.bend = {d2[6:0], d1[6:0]};
        end else begin
            c.typ  = 2'd1;
            c.note = d1[6:0];
            c.vel  = d2[6:0];
`ifdef NOTEON_VEL0_AS_OFF_EN
            if (d2[6:0] == 7'd0) begin
                c.typ  = 2'd0;
                c.note = 7'd0;
            end
`endif
        end
        return c;
    endfunction

    always @(posedge i_clk) begin
        bit   err, com, ok, full, pop;
        cmd_t c;
        if (i_reset) begin
            mq.delete();
            cur.delete();
            idle_cnt = 0;
            merr     = 0;
        end else begin
            err = 0; com = 0; c = '0;
            if (i_rx_valid) begin
                idle_cnt = 0;
                if (cur.size() == 0) begin
                    if (is_hdr(i_rx_byte)) cur.push_back(i_rx_byte);
                    else err = 1;
                end else begin
                    if (cur.size() == 1) ok = !i_rx_byte[7] && (int'(i_rx_byte) < NV);
                    else                 ok = !i_rx_byte[7];
                    if (!ok) begin
                        err = 1;
                        cur.delete();
                        if (is_hdr(i_rx_byte)) cur.push_back(i_rx_byte);
                    end else begin
                        cur.push_back(i_rx_byte);
                        if (cur[0] == 8'h80 && cur.size() == 2) begin
                            c = build(cur[0], cur[1], 8'h00, 8'h00);
                            com = 1;
                            cur.delete();
                        end else if (cur.size() == 4) begin
                            c = build(cur[0], cur[1], cur[2], cur[3]);
                            com = 1;
                            cur.delete();
                        end
                    end
                end
            end else if (cur.size() > 0) begin
                if (idle_cnt == TMO) begin
                    err = 1;
                    cur.delete();
                    idle_cnt = 0;
                end else begin
                    idle_cnt++;
                end
            end
            full = (mq.size() == FD);
            pop  = (mq.size() > 0) && i_cmd_ready;
            if (pop) void'(mq.pop_front());
            if (com) begin
                if (full && !pop) err = 1;
                else mq.push_back(c);
            end
            if (err && merr != 255) merr++;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge i_clk) begin
        cmd_t h;
        if (chk_en) begin
            h = '0;
            if (mq.size() > 0) h = mq[0];
            check("cmp_valid", 64'(o_cmd_valid), 64'(mq.size() > 0));
            check("cmp_err", 64'(o_err_count), 64'(merr));
            check("cmp_head", 64'({o_cmd_type, o_cmd_voice, o_cmd_note, o_cmd_velocity, o_cmd_bend}), 64'(h));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic v, input logic [7:0] b, input logic r);
        @(negedge i_clk);
        i_rx_valid  = v;
        i_rx_byte   = b;
        i_cmd_ready = r;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0);
    endtask

    // Pops the head; on return the next head is visible.
    task automatic pop1();
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 2) begin
            case ($urandom_range(0, 2))
                0:       return 8'h90;
                1:       return 8'h80;
                default: return 8'hE0;
            endcase
        end
        if (sel <= 5) return 8'($urandom_range(0, NV + 3));
        if (sel <= 8) return 8'($urandom_range(0, 127));
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int rdy_pct;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        chk_en  = 1'b1;
        check("rst_valid", 64'(o_cmd_valid), 64'd0);
        check("rst_err", 64'(o_err_count), 64'd0);
        check("rst_bend", 64'(o_cmd_bend), 64'd0);

        // NOTEON basic, with latency pinned
        send(8'h90); send(8'h03); send(8'h3C); send(8'h64);
        check("on_pre_valid", 64'(o_cmd_valid), 64'd0);
        gap(1);
        check("on_valid", 64'(o_cmd_valid), 64'd1);
        check("on_fields", 64'({o_cmd_type, o_cmd_voice, o_cmd_note, o_cmd_velocity, o_cmd_bend}),
              64'({2'd1, 4'd3, 7'd60, 7'd100, 14'h2000}));
        pop1();
        check("on_popped", 64'(o_cmd_valid), 64'd0);

        // NOTEOFF then PITCHBEND, order preserved
        send(8'h80); send(8'h05); send(8'hE0); send(8'h02); send(8'h00); send(8'h40);
        gap(1);
        check("off_fields", 64'({o_cmd_type, o_cmd_voice, o_cmd_note, o_cmd_velocity, o_cmd_bend}),
              64'({2'd0, 4'd5, 7'd0, 7'd0, 14'h2000}));
        pop1();
        check("pb_fields", 64'({o_cmd_type, o_cmd_voice, o_cmd_bend}), 64'({2'd2, 4'd2, 14'h2000}));
        pop1();

        // voice out of range, then a good message
        send(8'h90); send(8'h20); gap(1);
        check("vrange_err", 64'(o_err_count), 64'd1);
        check("vrange_nocmd", 64'(o_cmd_valid), 64'd0);
        send(8'h90); send(8'h01); send(8'h40); send(8'h10); gap(1);
        check("vrange_next", 64'({o_cmd_voice, o_cmd_note, o_cmd_velocity}), 64'({4'd1, 7'h40, 7'h10}));
        pop1();

        // header mid-message resyncs
        send(8'h90); send(8'h01); send(8'h90); send(8'h02); send(8'h3C); send(8'h7F); gap(1);
        check("resync_err", 64'(o_err_count), 64'd2);
        check("resync_cmd", 64'({o_cmd_voice, o_cmd_note, o_cmd_velocity}), 64'({4'd2, 7'd60, 7'd127}));
        pop1();

        // timeout after TMO+1 idle cycles, then orphan data bytes
        send(8'h90); send(8'h01); gap(TMO + 2);
        check("tmo_err", 64'(o_err_count), 64'd3);
        send(8'h3C); gap(1);
        check("tmo_orphan_err", 64'(o_err_count), 64'd4);
        send(8'h64); gap(1);
        check("tmo_orphan_err2", 64'(o_err_count), 64'd5);
        check("tmo_nocmd", 64'(o_cmd_valid), 64'd0);

        // byte arriving exactly on the timeout cycle wins
        send(8'h90); send(8'h01); gap(TMO); send(8'h3C); send(8'h64); gap(1);
        check("tmo_edge_valid", 64'(o_cmd_valid), 64'd1);
        check("tmo_edge_err", 64'(o_err_count), 64'd5);
        pop1();

        // overflow: five NOTEOFFs into a 4-deep FIFO
        for (int v = 1; v <= 5; v++) begin send(8'h80); send(8'(v)); end
        gap(1);
        check("ovf_err", 64'(o_err_count), 64'd6);
        for (int v = 1; v <= 4; v++) begin
            check("ovf_order", 64'(o_cmd_voice), 64'(v));
            pop1();
        end
        check("ovf_drained", 64'(o_cmd_valid), 64'd0);

        // NOTEON with velocity 0
        send(8'h90); send(8'h01); send(8'h3C); send(8'h00); gap(1);
`ifdef NOTEON_VEL0_AS_OFF_EN
        check("vel0", 64'({o_cmd_type, o_cmd_voice, o_cmd_note, o_cmd_velocity}), 64'({2'd0, 4'd1, 7'd0, 7'd0}));
`else
        check("vel0", 64'({o_cmd_type, o_cmd_voice, o_cmd_note, o_cmd_velocity}), 64'({2'd1, 4'd1, 7'd60, 7'd0}));
`endif
        pop1();

        // full FIFO with commit and pop in the same cycle is accepted
        for (int v = 8; v <= 11; v++) begin send(8'h80); send(8'(v)); end
        send(8'h80); tick(1'b1, 8'h07, 1'b1); gap(1);
        check("fullpop_err", 64'(o_err_count), 64'd6);
        check("fullpop_head", 64'(o_cmd_voice), 64'd9);
        for (int k = 0; k < 3; k++) pop1();
        check("fullpop_last", 64'(o_cmd_voice), 64'd7);
        pop1();

        // reset mid-message flushes FIFO and partial message
        send(8'h80); send(8'h03); send(8'h90); send(8'h01); send(8'h3C);
        @(negedge i_clk); i_rx_valid = 1'b0; i_reset = 1'b1;
        @(negedge i_clk); i_reset = 1'b0;
        check("rst_mid_valid", 64'(o_cmd_valid), 64'd0);
        check("rst_mid_err", 64'(o_err_count), 64'd0);
        send(8'h64); gap(1);
        check("rst_mid_orphan", 64'(o_err_count), 64'd1);

        // randomized traffic
        rdy_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rdy_pct = (i / 500) % 3 == 0 ? 10 : ((i / 500) % 3 == 1 ? 50 : 90);
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < TMO - 1 + int'($urandom_range(0, 3)); k++)
                    tick(1'b0, 8'h00, 1'($urandom_range(0, 99) < rdy_pct));
            end
            tick(1'($urandom_range(0, 9) < 6), rand_byte(), 1'($urandom_range(0, 99) < rdy_pct));
        end
        gap(2);

        // error counter saturation
        @(negedge i_clk); i_reset = 1'b1;
        @(negedge i_clk); i_reset = 1'b0;
        for (int k = 0; k < 300; k++) send(8'h00);
        gap(1);
        check("err_sat", 64'(o_err_count), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
